ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//   Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.
//   Runs the request-to-send sequence, shifts bits on device clock falling edges and checks the device ACK.
//   Sits beside the receive path on the same open-drain PS/2 lines; top level builds tri-states from *_oe.
//   The receive path must ignore line activity while o_busy=1.
// PARAMETERS
//   INHIBIT_CYCLES   5000     clk cycles PS/2 clock held low for request-to-send (>=100us at 50MHz)
//   TIMEOUT_CYCLES   750000   watchdog limit from leaving IDLE to end of ACK (15ms at 50MHz)
//   CNT_W            20       width of the shared cycle counter; must hold both limits
// PORTS
//   clk            in   1  system clock
//   i_sclr         in   1  reset, asynchronous, active-high
//   i_valid        in   1  request to send i_byte; accepted only when o_ready=1
//   i_byte         in   8  command byte, captured on acceptance
//   o_ready        out  1  1 in IDLE only
//   o_busy         out  1  1 whenever not IDLE
//   o_done         out  1  one-cycle pulse: transfer finished (ACK seen or error)
//   o_err          out  1  valid with o_done: 1 = no ACK (data high at ACK edge) or timeout
//   i_ps2_clk      in   1  raw PS/2 clock line (async)
//   i_ps2_dat      in   1  raw PS/2 data line (async)
//   o_ps2_clk_oe   out  1  1 = drive PS/2 clock low, 0 = release
//   o_ps2_dat_oe   out  1  1 = drive PS/2 data low, 0 = release
// BEHAVIOUR
//   Reset (async): state IDLE; o_ready=1, o_busy=0, o_done=0, o_err=0, both *_oe=0, counters 0.
//   Line inputs pass a 2-FF synchroniser; falling edge = prev & ~cur (3-cycle detect latency).
//   Handshake: i_valid & o_ready in cycle N -> byte and odd parity (~^i_byte) latched; INHIBIT from N+1.
//   i_valid while busy is ignored; no queueing.
//   States:
//     IDLE    -> INHIBIT on accept.
//     INHIBIT clk_oe=1, dat_oe=0 for INHIBIT_CYCLES, then RTS.
//     RTS     dat_oe=1 (start bit 0) one cycle with clk_oe=1, then clk_oe=0 -> SHIFT.
//     SHIFT   edge counter k=1..10 on each device falling edge:
//             k=1..8 dat_oe=~byte[k-1] (LSB first), k=9 dat_oe=~parity, k=10 dat_oe=0 (stop).
//             At k=10 -> ACK.
//     ACK     next falling edge: sample synced data; low=ACK ok, high=err.
//             -> WAIT_IDLE.
//     WAIT_IDLE  wait synced clk=1 and dat=1, then o_done pulse, -> IDLE.
//   o_err holds until the next accept; o_done is a single cycle.
//   dat_oe only changes in the cycle after a detected falling edge (device samples on rising).
//   Glitch: a falling edge seen during INHIBIT/RTS is ignored.
//   i_sclr mid-transfer: both lines released immediately; no o_done.
// CONFIGURATION
//   PS2_TX_TIMEOUT_EN defined:
//     watchdog counts from leaving IDLE.
//     At TIMEOUT_CYCLES in any non-IDLE state: release lines, o_done=1, o_err=1, -> IDLE.
//   Undefined: no watchdog; a silent device holds o_busy=1 until i_sclr.
// STRUCTURE
//   ps2_defs.vh (include-guarded):
//     state encodings IDLE/INHIBIT/RTS/SHIFT/ACK/WAIT_IDLE (3-bit);
//     PS2 command constants 0xED, 0xF4, 0xFF.
//   Sub-module ps2_line_sync: 2-FF sync of clk and dat plus falling-edge pulse, async reset.
//   Shared receive-side use of ps2_line_sync is permitted.
//   Top: one cycle counter (INHIBIT and watchdog), 4-bit edge counter, 9-bit shift register.
// TESTING  (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clock period 40 clk)
//   1 send 0xED -> clk low exactly 20 cycles then start bit;
//     model samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//     model ACKs -> o_done=1, o_err=0.
//   2 send 0xF4 -> model samples 0,0,1,0,1,1,1,1, parity 0; o_err=0.
//   3 send 0x00, model gives no ACK (data high) -> o_done=1, o_err=1.
//   4 i_valid with 0x55 while busy sending 0xFF -> model sees only 0xFF; o_ready stays 0 until done.
//   5 PS2_TX_TIMEOUT_EN, model never clocks -> o_done with o_err=1 at ~2000 cycles; lines released.
//   6 assert i_sclr at edge 5 of 0xED -> both *_oe=0 same cycle, o_ready=1, no o_done; next 0xF4 sends clean.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// common keyboard command bytes and the parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // PS/2 frames carry odd parity: the bit makes the 9-bit total odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines plus a
// falling-edge pulse on the synchronised clock. Usable by the receive side too.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic ps2_clk_o,
    output logic ps2_dat_o,
    output logic clk_fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Flops reset high (idle bus level) so reset release never fakes an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign ps2_clk_o  = clk_sync_q[1];
    assign ps2_dat_o  = dat_sync_q[1];
    assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, LSB-first shift of
// byte + odd parity + stop on device falling edges, then ACK check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             clk_s, dat_s, clk_fall;
    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q;
    logic [8:0]       shreg_q;
    logic             ready_q, busy_q, done_q, err_q, clk_oe_q, dat_oe_q;

    ps2_line_sync u_sync (
        .clk_i      (clk),
        .rst_i      (i_sclr),
        .ps2_clk_i  (i_ps2_clk),
        .ps2_dat_i  (i_ps2_dat),
        .ps2_clk_o  (clk_s),
        .ps2_dat_o  (dat_s),
        .clk_fall_o (clk_fall)
    );

    // One counter times the inhibit phase and the watchdog; it parks at the
    // watchdog limit so a stalled transfer never wraps it.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != TMO_LAST) cnt_d = cnt_q + CNT_W'(1);
    end

    // Transfer FSM with registered handshake and line-drive outputs.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            shreg_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE) cnt_q <= cnt_d;
            case (state_q)
                ST_IDLE: if (i_valid) begin
                    shreg_q  <= {odd_parity(i_byte), i_byte};
                    cnt_q    <= '0;
                    edge_q   <= '0;
                    err_q    <= 1'b0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    clk_oe_q <= 1'b1;
                    dat_oe_q <= 1'b0;
                    state_q  <= ST_INHIBIT;
                end
                ST_INHIBIT: if (cnt_q == INH_LAST) begin
                    dat_oe_q <= 1'b1;               // start bit under inhibit
                    state_q  <= ST_RTS;
                end
                ST_RTS: begin
                    clk_oe_q <= 1'b0;               // hand the clock to the device
                    state_q  <= ST_SHIFT;
                end
                // Data moves only after a device falling edge; it samples on rising.
                ST_SHIFT: if (clk_fall) begin
                    edge_q <= edge_q + 4'd1;
                    if (edge_q == 4'd9) begin
                        dat_oe_q <= 1'b0;           // stop bit: release
                        state_q  <= ST_ACK;
                    end else begin
                        dat_oe_q <= ~shreg_q[0];
                        shreg_q  <= {1'b1, shreg_q[8:1]};
                    end
                end
                ST_ACK: if (clk_fall) begin
                    err_q   <= dat_s;               // device pulls data low to ACK
                    state_q <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: if (clk_s && dat_s) begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides everything: abandon the frame and report error.
            if (state_q != ST_IDLE && cnt_q == TMO_LAST) begin
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                done_q   <= 1'b1;
                err_q    <= 1'b1;
                ready_q  <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
            end
`endif
        end
    end

    assign o_ready      = ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_ps2_clk_oe = clk_oe_q;
    assign o_ps2_dat_oe = dat_oe_q;

endmodule
